gps_uart_rx: RTL and testbench
==============================

# gps_uart_rx

Serial receiver for the GPS NMEA link. Oversamples the asynchronous RxD pin at 16× baud, recovers 8N1 characters (optionally 8E1), and presents each byte as a one-cycle strobe. It sits directly upstream of the NMEA parser, whose RxD_data_in / RxD_data_in_ready inputs connect straight to this block's RxD_data / RxD_data_ready outputs.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency, Hz.
- BAUD, 9600: line rate, bits/s.
- OVERSAMPLE, 16: samples per bit, fixed power of two ≥ 8.
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  reset, synchronous, active-high.
- RxD  input  1  asynchronous serial line, idle high.
- RxD_data  output  8  received byte, LSB first on the wire; held until the next accepted byte.
- RxD_data_ready  output  1  one-cycle strobe: RxD_data valid and new.
- RxD_frame_err  output  1  one-cycle strobe: stop bit sampled low (or parity mismatch, see Configuration).

## Operation
- RxD passes through a 2-flop synchronizer (both flops reset to 1) before any use.
- Tick generator: counter divides CLK by DIV = round(CLK_FREQ / (BAUD·OVERSAMPLE)), producing a 1-cycle tick. Counter free-runs only outside IDLE; entering START reloads it to 0.
- Sample counter (4 bits for OVERSAMPLE=16) counts ticks within a bit; a bit is sampled when the counter reaches OVERSAMPLE/2−1 (start) or OVERSAMPLE−1 relative to the previous sample (data/parity/stop), i.e. at mid-bit.
- States:
  - IDLE: wait for synchronized RxD = 0 → START.
  - START: at mid-bit, RxD still 0 → DATA (bit index 0); RxD = 1 → IDLE (glitch rejected, no strobe).
  - DATA: shift sampled bit into shift register MSB, shift right; after bit 7 → PARITY if enabled, else STOP.
  - PARITY: sample, compare against even parity of the 8 data bits → STOP.
  - STOP: at mid-bit: RxD = 1 and no parity error → load RxD_data, pulse RxD_data_ready, → IDLE. Otherwise pulse RxD_frame_err, RxD_data unchanged, → WAIT_IDLE.
  - WAIT_IDLE: stay until synchronized RxD = 1, then → IDLE (prevents a break condition from generating back-to-back false frames).
- Returning to IDLE at mid-stop permits a following start bit to be detected immediately (back-to-back characters at full rate).
- Reset values: RxD_data = 0, RxD_data_ready = 0, RxD_frame_err = 0, state IDLE, all counters 0. RST asserted mid-character aborts it; no strobe is issued for the partial byte.
- RxD_data_ready and RxD_frame_err are never high in the same cycle.

## Timing
- Synchronizer latency: 2 cycles from pin to FSM.
- Strobe cycle: registered, asserted the cycle after the mid-stop-bit sample tick; exactly 1 cycle wide.
- Falling edge at pin → RxD_data_ready ≈ 9.5 bit periods (10.5 with parity) + 3 cycles.
- Tolerated baud mismatch: ±4 % total per character.
- DIV < 1 is illegal; no elaboration-time check is required beyond a `$error` in simulation.

## Configuration
- UART_RX_PARITY_EN defined: 8E1 framing; PARITY state present; parity mismatch reported via RxD_frame_err (byte discarded, → WAIT_IDLE only if stop also low, else → IDLE).
- Undefined: 8N1; PARITY state and its logic absent; RxD_frame_err only for bad stop bit.

## Structure
- Shared package gps_pkg: state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE), ASCII constants used across the GPS path ("$", ",", LF).
- One sub-module: uart_baud_tick (parameterized divider with synchronous clear, 1-cycle tick output).

## Test plan
Bench: CLK_FREQ=1_600_000, BAUD=10_000 → DIV=10, 160 cycles/bit.
- Send 0x24 ("$") 8N1 → single RxD_data_ready pulse, RxD_data = 8'h24, RxD_frame_err stays 0.
- Send "GGA," back-to-back, no idle between stop and next start → four strobes, data 8'h47, 8'h47, 8'h41, 8'h2C.
- RxD low for 40 cycles then high → no strobe, FSM back in IDLE; following 0x0A received correctly.
- Send 0x55 with stop bit low, line held low 3 bit times → one RxD_frame_err pulse, RxD_data keeps prior value, no further strobes until line high; next 0x31 received correctly.
- Assert RST for 1 cycle during data bit 4 of 0xA5 → no strobe for that byte, outputs 0; next 0x3C received correctly.
- With UART_RX_PARITY_EN: 0x03 with parity bit 1 → RxD_frame_err pulse, no ready; with parity 0 → RxD_data = 8'h03.

Source files
------------

// File: rtl/gps_pkg.sv
// gps_pkg: shared receiver state encoding and ASCII constants for the GPS NMEA path
package gps_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} rx_state_e;
  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk by DIV into a 1-cycle tick, held at phase 0 while clr is high
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  if (DIV < 1) begin : g_bad_div
    $error("uart_baud_tick: DIV must be >= 1");
  end
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/gps_uart_rx.sv
// gps_uart_rx: 16x-oversampled 8N1 receiver for the NMEA link; define UART_RX_PARITY_EN for 8E1
module gps_uart_rx
  import gps_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_frame_err
);
  localparam int DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  rx_state_e state, state_n;
  logic [1:0] sync;
  logic [SW-1:0] scnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic rx, tick, samp, done, ok, perr;
  assign rx = sync[1];
  always_ff @(posedge CLK)
    if (RST) sync <= 2'b11;
    else sync <= {sync[0], RxD};
  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk (CLK),
    .rst (RST),
    .clr (state == IDLE),
    .tick(tick)
  );
  // start bit is sampled half a bit in; every later sample is one full bit after the previous
  assign samp = tick && scnt == (state == START ? SW'(OVERSAMPLE / 2 - 1) : SW'(OVERSAMPLE - 1));
  assign done = state == STOP && samp;
  assign ok   = rx && !perr;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = PARITY;
  always_ff @(posedge CLK)
    if (RST) perr <= 1'b0;
    else if (state == PARITY && samp) perr <= rx ^ (^sh);
`else
  localparam rx_state_e AFTER_DATA = STOP;
  assign perr = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = rx ? IDLE : START;
      START:     if (samp) state_n = rx ? IDLE : DATA;
      DATA:      if (samp && idx == 3'd7) state_n = AFTER_DATA;
      PARITY:    if (samp) state_n = STOP;
      STOP:      if (samp) state_n = rx ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state          <= IDLE;
      scnt           <= '0;
      idx            <= '0;
      sh             <= '0;
      RxD_data       <= '0;
      RxD_data_ready <= 1'b0;
      RxD_frame_err  <= 1'b0;
    end else begin
      state          <= state_n;
      scnt           <= (state == IDLE || samp) ? '0 : tick ? scnt + SW'(1) : scnt;
      idx            <= state != DATA ? '0 : samp ? idx + 3'd1 : idx;
      if (state == DATA && samp) sh <= {rx, sh[7:1]};
      if (done && ok) RxD_data <= sh;
      RxD_data_ready <= done && ok;
      RxD_frame_err  <= done && !ok;
    end
endmodule

// File: tb/tb_gps_uart_rx.sv
// tb_gps_uart_rx: directed bench for gps_uart_rx at 160 clocks per bit; honours UART_RX_PARITY_EN
module tb_gps_uart_rx;
  import gps_pkg::*;
  localparam int CPB = 160;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = CPB * (19 + 2 * PB) / 2 + 3;
  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic [7:0] exp_d;
    int         exp_rdy;
    int         exp_err;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, rxd = 1'b1;
  logic [7:0] data;
  logic rdy, ferr;
  int cyc = 0, rdy_n = 0, err_n = 0, both_n = 0, rdy_cyc = 0, t_start = 0;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  vec_t v[7];
  gps_uart_rx #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16)) dut (
    .CLK           (clk),
    .RST           (rst),
    .RxD           (rxd),
    .RxD_data      (data),
    .RxD_data_ready(rdy),
    .RxD_frame_err (ferr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rdy) begin
      rdy_n++;
      rdy_cyc = cyc;
      q.push_back(data);
    end
    if (ferr) err_n++;
    if (rdy && ferr) both_n++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic pbad);
    rxd = 1'b0;
    t_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^d) ^ pbad;
    repeat (CPB) @(negedge clk);
`endif
    rxd = stop;
    repeat (CPB) @(negedge clk);
  endtask
  initial begin
    int r0, e0, qb;
    logic [7:0] gga [4];
    logic [7:0] a5;
    gga = '{8'h47, 8'h47, 8'h41, 8'h2C};
    a5 = 8'hA5;
    v[0] = '{8'h24, 1'b1, 8'h24, 1, 0};
    v[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    v[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    v[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
    v[4] = '{8'h7E, 1'b0, 8'h80, 0, 1};
    v[5] = '{8'h01, 1'b1, 8'h01, 1, 0};
    v[6] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_data", data, 8'h00);
    chk("reset_ready", rdy, 1'b0);
    chk("reset_err", ferr, 1'b0);
    chk("reset_state", dut.state, IDLE);
    idle(CPB);
    for (int i = 0; i < 7; i++) begin
      r0 = rdy_n;
      e0 = err_n;
      send(v[i].d, v[i].stop, 1'b0);
      idle(2 * CPB);
      chk($sformatf("vec%0d_ready", i), rdy_n - r0, v[i].exp_rdy);
      chk($sformatf("vec%0d_err", i), err_n - e0, v[i].exp_err);
      chk($sformatf("vec%0d_data", i), data, v[i].exp_d);
      if (v[i].exp_rdy == 1) chk($sformatf("vec%0d_latency", i), rdy_cyc - t_start, LAT);
    end
    r0 = rdy_n;
    qb = q.size();
    for (int i = 0; i < 4; i++) send(gga[i], 1'b1, 1'b0);
    idle(2 * CPB);
    chk("gga_count", rdy_n - r0, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("gga_byte%0d", i), q.size() > qb + i ? q[qb + i] : 8'h00, gga[i]);
    r0 = rdy_n;
    e0 = err_n;
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    idle(2 * CPB);
    chk("glitch_ready", rdy_n - r0, 0);
    chk("glitch_err", err_n - e0, 0);
    chk("glitch_state", dut.state, IDLE);
    send(ASCII_LF, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("after_glitch_ready", rdy_n - r0, 1);
    chk("after_glitch_data", data, 8'h0A);
    r0 = rdy_n;
    e0 = err_n;
    send(8'h55, 1'b0, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("break_state", dut.state, WAIT_IDLE);
    idle(2 * CPB);
    chk("break_err", err_n - e0, 1);
    chk("break_ready", rdy_n - r0, 0);
    chk("break_data", data, 8'h0A);
    send(8'h31, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("after_break_data", data, 8'h31);
    chk("after_break_ready", rdy_n - r0, 1);
    r0 = rdy_n;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = a5[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = a5[4];
    repeat (120) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", data, 8'h00);
    chk("midrst_ready", rdy, 1'b0);
    chk("midrst_err", ferr, 1'b0);
    repeat (CPB - 121) @(negedge clk);
    for (int i = 5; i < 8; i++) begin
      rxd = a5[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rxd = ^a5;
    repeat (CPB) @(negedge clk);
`endif
    rxd = 1'b1;
    repeat (CPB) @(negedge clk);
    chk("midrst_no_strobe", rdy_n - r0, 0);
    idle(12 * CPB);
    send(8'h3C, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("after_rst_data", data, 8'h3C);
`ifdef UART_RX_PARITY_EN
    r0 = rdy_n;
    e0 = err_n;
    send(8'h03, 1'b1, 1'b1);
    idle(2 * CPB);
    chk("par_bad_err", err_n - e0, 1);
    chk("par_bad_ready", rdy_n - r0, 0);
    chk("par_bad_data", data, 8'h3C);
    send(8'h03, 1'b1, 1'b0);
    idle(2 * CPB);
    chk("par_ok_ready", rdy_n - r0, 1);
    chk("par_ok_data", data, 8'h03);
`endif
    chk("never_both", both_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
